sumres_display_n: RTL and testbench

- Parametrised successor of the 4-bit add/subtract-with-display top.
- Captures two unsigned WIDTH-bit operands and computes a+b or a-b as sign plus magnitude.
- Converts the magnitude to BCD with a sequential double-dabble engine.
- Drives a DIGITS-wide time-multiplexed 7-segment display plus a sign LED, all on one clock.

---
 rtl/sumres_display_n.sv | 198 +++++++++++++++++++
 tb/tb_sumres_display_n.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/sumres_display_n.sv
// sumres_display_n: adds or subtracts two unsigned operands and shows the
// signed result on a time-multiplexed 7-segment display.
//
// The result is held as sign plus magnitude. A free-running LOAD -> SHIFT ->
// UPDATE sequencer converts the magnitude to BCD with a double-dabble engine.
// Only a finished conversion is copied into the display registers.
//
// Ports:
//   clk_in  system clock, rising edge
//   rst     synchronous, active-high reset
//   in_a    operand A, unsigned, WIDTH bits
//   in_b    operand B, unsigned, WIDTH bits
//   op      0 = A+B, 1 = A-B
//   seg     segments a..g on seg[6]..seg[0], active-high
//   sign0   1 = displayed result is negative
//   an      digit enables, active-low, one-hot-cold; digit 0 is the units digit
//   valid   1 once the first conversion has reached the display registers
//   ovf     1 = magnitude does not fit in DIGITS decimal digits
//
// Build option: defining SUMRES_BLANK_LEADING_ZERO_EN blanks leading-zero
// digits above the units digit.
module sumres_display_n #(
  parameter int WIDTH    = 4,
  parameter int DIGITS   = 2,
  parameter int SCAN_DIV = 50000
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic [WIDTH-1:0]  in_a,
  input  logic [WIDTH-1:0]  in_b,
  input  logic              op,
  output logic [6:0]        seg,
  output logic              sign0,
  output logic [DIGITS-1:0] an,
  output logic              valid,
  output logic              ovf
);

  // Number of BCD nibbles: decimal digits of the largest magnitude, plus one.
  function automatic int calc_nib(input int bits);
    longint unsigned lim;
    int n;
    lim = (64'd1 << bits) - 64'd1;
    n   = 0;
    for (int i = 0; i < 24; i++) begin
      if (lim != 0) begin
        lim = lim / 10;
        n++;
      end
    end
    return n + 1;
  endfunction

  localparam int RES_W   = WIDTH + 1;
  localparam int NIB_MIN = calc_nib(RES_W);
  localparam int NIB     = (NIB_MIN > DIGITS) ? NIB_MIN : DIGITS;
  localparam int SR_W    = 4 * NIB + RES_W;
  localparam int CNT_W   = $clog2(RES_W + 1);
  localparam int SC_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {LOAD, SHIFT, UPDATE} state_t;

  // Add 3 to every nibble that is 5 or more, ahead of the next left shift.
  function automatic logic [4*NIB-1:0] dabble(input logic [4*NIB-1:0] bcd);
    logic [4*NIB-1:0] r;
    r = bcd;
    for (int i = 0; i < NIB; i++) begin
      if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1111110;
      4'd1:    return 7'b0110000;
      4'd2:    return 7'b1101101;
      4'd3:    return 7'b1111001;
      4'd4:    return 7'b0110011;
      4'd5:    return 7'b1011011;
      4'd6:    return 7'b1011111;
      4'd7:    return 7'b1110000;
      4'd8:    return 7'b1111111;
      4'd9:    return 7'b1111011;
      default: return 7'b0000000;
    endcase
  endfunction

  state_t            state;
  logic [SR_W-1:0]   sr;
  logic [CNT_W-1:0]  bit_cnt;
  logic              conv_sign;
  logic [3:0]        disp [DIGITS];
  logic [SC_W-1:0]   scan_cnt;
  logic [IDX_W-1:0]  idx;

  logic [RES_W-1:0]  mag_c;
  logic              sign_c;
  logic              ovf_c;
  logic              blank;
  logic [6:0]        seg_n;
  logic [DIGITS-1:0] an_n;

  // Sign/magnitude of the live inputs; a zero difference takes the a>=b path.
  always_comb begin
    mag_c  = RES_W'(in_a) + RES_W'(in_b);
    sign_c = 1'b0;
    if (op) begin
      if (in_a >= in_b) begin
        mag_c = RES_W'(in_a - in_b);
      end else begin
        mag_c  = RES_W'(in_b - in_a);
        sign_c = 1'b1;
      end
    end
  end

  // Any nonzero nibble beyond the displayed digits means overflow.
  always_comb begin
    ovf_c = 1'b0;
    for (int i = DIGITS; i < NIB; i++) begin
      ovf_c = ovf_c | (|sr[RES_W + 4*i +: 4]);
    end
  end

  // Conversion sequencer: LOAD -> SHIFT x RES_W -> UPDATE.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      state <= LOAD;
      valid <= 1'b0;
      sign0 <= 1'b0;
      ovf   <= 1'b0;
      for (int i = 0; i < DIGITS; i++) disp[i] <= 4'd0;
    end else begin
      case (state)
        LOAD: begin
          sr        <= SR_W'(mag_c);
          conv_sign <= sign_c;
          bit_cnt   <= CNT_W'(RES_W);
          state     <= SHIFT;
        end
        SHIFT: begin
          sr      <= {dabble(sr[SR_W-1:RES_W]), sr[RES_W-1:0]} << 1;
          bit_cnt <= bit_cnt - CNT_W'(1);
          if (bit_cnt == CNT_W'(1)) state <= UPDATE;
        end
        UPDATE: begin
          for (int i = 0; i < DIGITS; i++) disp[i] <= sr[RES_W + 4*i +: 4];
          sign0 <= conv_sign;
          ovf   <= ovf_c;
          valid <= 1'b1;
          state <= LOAD;
        end
        default: state <= LOAD;
      endcase
    end
  end

  // Segment/anode selection for the current digit slot.
  always_comb begin
    blank = 1'b0;
`ifdef SUMRES_BLANK_LEADING_ZERO_EN
    // Blank a non-units digit when it and every higher digit are zero.
    if (idx != '0) begin
      blank = 1'b1;
      for (int i = 1; i < DIGITS; i++) begin
        if (i >= int'(idx) && disp[i] != 4'd0) blank = 1'b0;
      end
    end
`endif
    if (!valid)       seg_n = 7'b0000000;
    else if (ovf)     seg_n = 7'b0000001;
    else if (blank)   seg_n = 7'b0000000;
    else              seg_n = decode(disp[idx]);
    an_n = valid ? ~(DIGITS'(1) << idx) : '1;
  end

  // Scan: seg and an are registered together so they switch in the same cycle.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      scan_cnt <= '0;
      idx      <= '0;
      an       <= '1;
      seg      <= 7'b0000000;
    end else begin
      if (scan_cnt == SC_W'(SCAN_DIV - 1)) begin
        scan_cnt <= '0;
        idx      <= (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + IDX_W'(1);
      end else begin
        scan_cnt <= scan_cnt + SC_W'(1);
      end
      an  <= an_n;
      seg <= seg_n;
    end
  end

endmodule

// File: tb/tb_sumres_display_n.sv
// Bench for sumres_display_n: two instances (WIDTH=4 and WIDTH=8, both two
// digits, fast scan). Operands are applied and held; the expected display
// frame is queued from an arithmetic reference model, and a monitor pops and
// compares whenever the DUT completes a full digit-0/digit-1 scan frame.
module tb_sumres_display_n;
  localparam int SD = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [3:0] a0, b0;
  logic       op0;
  logic [6:0] seg0;
  logic       sgn0, vld0, ov0;
  logic [1:0] an0;
  logic [7:0] a1, b1;
  logic       op1;
  logic [6:0] seg1;
  logic       sgn1, vld1, ov1;
  logic [1:0] an1;

  sumres_display_n #(.WIDTH(4), .DIGITS(2), .SCAN_DIV(SD)) dut0 (
    .clk_in(clk), .rst(rst), .in_a(a0), .in_b(b0), .op(op0),
    .seg(seg0), .sign0(sgn0), .an(an0), .valid(vld0), .ovf(ov0));

  sumres_display_n #(.WIDTH(8), .DIGITS(2), .SCAN_DIV(SD)) dut1 (
    .clk_in(clk), .rst(rst), .in_a(a1), .in_b(b1), .op(op1),
    .seg(seg1), .sign0(sgn1), .an(an1), .valid(vld1), .ovf(ov1));

  int checks = 0;
  int passed = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  typedef struct {
    int    unit;
    int    sg;
    int    ov;
    int    s0;
    int    s1;
    string tag;
  } exp_t;

  exp_t q[$];

  localparam logic [6:0] SEGTAB [10] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
    7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};

  // Reference: signed result by plain arithmetic, digits by division.
  function automatic exp_t model(input int u, input int a, input int b, input int o,
                                 input string tag);
    exp_t e;
    int   res, mag;
    res   = (o == 0) ? a + b : a - b;
    mag   = (res < 0) ? -res : res;
    e.unit = u;
    e.tag  = tag;
    e.sg   = (res < 0) ? 1 : 0;
    e.ov   = (mag > 99) ? 1 : 0;
    if (e.ov == 1) begin
      e.s0 = 7'b0000001;
      e.s1 = 7'b0000001;
    end else begin
      e.s0 = int'(SEGTAB[mag % 10]);
      e.s1 = int'(SEGTAB[mag / 10]);
`ifdef SUMRES_BLANK_LEADING_ZERO_EN
      if (mag < 10) e.s1 = 0;
`endif
    end
    return e;
  endfunction

  // Monitor state: per-unit frame capture.
  logic [1:0] seen [2];
  logic [6:0] fs   [2][2];

  task automatic mon(input int u, input logic v, input logic [1:0] an,
                     input logic [6:0] s, input logic sg, input logic ov);
    exp_t e;
    int   k;
    if (!v) begin
      seen[u] = 2'b00;
    end else if (an == 2'b10 || an == 2'b01) begin
      k = (an == 2'b10) ? 0 : 1;
      fs[u][k]   = s;
      seen[u][k] = 1'b1;
      if (k == 1) begin
        if (seen[u] == 2'b11 && q.size() > 0 && q[0].unit == u) begin
          e = q.pop_front();
          chk({e.tag, "_sign"}, int'(sg), e.sg);
          chk({e.tag, "_ovf"},  int'(ov), e.ov);
          chk({e.tag, "_dig0"}, int'(fs[u][0]), e.s0);
          chk({e.tag, "_dig1"}, int'(fs[u][1]), e.s1);
        end
        seen[u] = 2'b00;
      end
    end
  endtask

  logic [1:0] prev_an = 2'b11;
  int         hold = 0;
  bit         tracking = 1'b0;

  always @(negedge clk) begin
    mon(0, vld0, an0, seg0, sgn0, ov0);
    mon(1, vld1, an1, seg1, sgn1, ov1);
    // Digit slot order and length on unit 0.
    if (!vld0) begin
      prev_an  = 2'b11;
      tracking = 1'b0;
      hold     = 0;
    end else if (an0 == prev_an) begin
      hold++;
    end else begin
      if (tracking) begin
        chk("slot_len", hold, SD);
        chk("slot_order", int'(an0), int'({prev_an[0], prev_an[1]}));
      end
      tracking = (prev_an != 2'b11);
      prev_an  = an0;
      hold     = 1;
    end
  end

  task automatic check_rst(input string tag);
    chk({tag, "_an"},    int'(an0),  3);
    chk({tag, "_seg"},   int'(seg0), 0);
    chk({tag, "_sign"},  int'(sgn0), 0);
    chk({tag, "_valid"}, int'(vld0), 0);
    chk({tag, "_ovf"},   int'(ov0),  0);
  endtask

  // Count clock edges from reset release until valid rises.
  task automatic lat(input string tag);
    int n;
    n = 0;
    while (!vld0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk(tag, n, 7);
  endtask

  task automatic apply(input int u, input int a, input int b, input int o, input string tag);
    int n;
    @(negedge clk);
    if (u == 0) begin
      a0 = 4'(a); b0 = 4'(b); op0 = o[0];
    end else begin
      a1 = 8'(a); b1 = 8'(b); op1 = o[0];
    end
    repeat (40) @(negedge clk);
    q.push_back(model(u, a, b, o, tag));
    n = 0;
    while (q.size() > 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (q.size() > 0) begin
      chk({tag, "_timeout"}, 0, 1);
      q.delete();
    end
  endtask

  initial begin
    seen[0] = 2'b00;
    seen[1] = 2'b00;
    rst = 1'b1;
    a0 = 4'($urandom); b0 = 4'($urandom); op0 = 1'($urandom);
    a1 = 8'($urandom); b1 = 8'($urandom); op1 = 1'($urandom);
    repeat (3) @(negedge clk);
    check_rst("reset");
    rst = 1'b0;
    lat("valid_latency");

    apply(0, 9, 5, 0, "add_9_5");
    apply(0, 3, 12, 1, "sub_3_12");
    apply(0, 7, 7, 1, "sub_7_7");
    apply(0, 15, 15, 0, "add_15_15");
    apply(1, 200, 100, 0, "w8_ovf");
    apply(1, 50, 0, 0, "w8_50");
    for (int i = 0; i < 12; i++)
      apply(0, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
            int'($urandom_range(0, 1)), "rnd4");
    for (int i = 0; i < 4; i++)
      apply(1, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
            int'($urandom_range(0, 1)), "rnd8");

    // Mid-run operand change: edges counted from reset release.
    @(negedge clk);
    rst = 1'b1;
    a0 = 4'd3; b0 = 4'd12; op0 = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);       // past the second LOAD
    a0 = 4'd12; b0 = 4'd3;           // changed while shifting
    repeat (12) @(negedge clk);      // edge 20: still the old result
    chk("midrun_old_sign", int'(sgn0), 1);
    @(negedge clk);                  // edge 21: UPDATE of the new operands
    chk("midrun_new_sign", int'(sgn0), 0);
    repeat (2) @(negedge clk);       // edge 23, mid SHIFT
    rst = 1'b1;
    @(negedge clk);
    check_rst("midrun_reset");
    rst = 1'b0;
    lat("midrun_valid_latency");
    apply(0, 8, 1, 1, "after_reset");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
